router_output_channel: RTL and testbench
========================================

// Module: router_output_channel
// PURPOSE
//  Transmit side of the router-to-router link; the partner of the input channel at the next hop.
//  Buffers outbound flits in two virtual channels: VC1 (even, polarity=0) and VC2 (odd, polarity=1).
//  Each cycle, serves only the VC matching the current polarity, and only when the downstream input channel asserts ready.
//  Drives send/data_out; sits between the router crossbar and the link wires.
// PARAMETERS
//  DATA_W    64  flit width in bits
//  VC_DEPTH  2   entries per virtual-channel FIFO (power of 2, >=2)
// PORTS
//  clk               input   1       single clock, rising edge
//  reset_n           input   1       asynchronous, active-low reset
//  polarity          input   1       global cycle parity; 0 selects VC1, 1 selects VC2
//  wr_valid          input   1       crossbar presents a flit this cycle
//  wr_vc             input   1       target VC of the flit: 0=VC1, 1=VC2
//  wr_data           input   DATA_W  flit from the crossbar
//  wr_ready_vc1      output  1       VC1 not full (combinational from occupancy)
//  wr_ready_vc2      output  1       VC2 not full (combinational from occupancy)
//  ds_ready          input   1       downstream input channel ready to accept
//  send              output  1       registered; flit valid on data_out
//  data_out          output  DATA_W  registered flit to the link; 0 when send=0
//  sent_cnt_vc1      output  16      flits sent from VC1 (ROUTER_OC_STATS_EN only)
//  sent_cnt_vc2      output  16      flits sent from VC2 (ROUTER_OC_STATS_EN only)
//  drop_cnt          output  16      writes refused while full (ROUTER_OC_STATS_EN only)
// BEHAVIOUR
//  - Reset (reset_n=0, async):
//    - both FIFOs emptied: rd/wr pointers and count = 0
//    - send=0, data_out=0, all counters 0
//    - wr_ready_vc1 = wr_ready_vc2 = 1 while in reset
//  - Per-VC FIFO: circular buffer with rd/wr pointers of clog2(VC_DEPTH) bits, wrapping at VC_DEPTH.
//    - Occupancy count is clog2(VC_DEPTH)+1 bits.
//  - Write: on posedge, if wr_valid and wr_ready of the VC selected by wr_vc, push wr_data into that VC.
//    - wr_valid while the selected VC is full: flit is dropped and no state changes (drop_cnt++ with stats).
//    - wr_ready depends only on occupancy == VC_DEPTH. A full VC refuses a write even when it pops in the same cycle.
//  - Transmit: on posedge, let V = VC1 if polarity=0, else VC2.
//    - If V is non-empty and ds_ready=1: send<=1, data_out<=head(V), pop V.
//    - Otherwise: send<=0, data_out<=0.
//    - The VC not selected by polarity never pops, even if non-empty.
//  - Latency:
//    - Flit written at edge N is eligible at edge N+1 at the earliest; it appears on send/data_out after edge N+1.
//    - Transmit is a single registered stage. ds_ready is sampled at the same edge that drives send.
//  - Simultaneous push+pop on one VC: occupancy unchanged, pointers both advance; legal whenever the VC is not full.
//  - Zero-valued flits are legal payload; validity is carried only by send.
//  - ds_ready low: the selected VC holds its contents and send=0. No timeout and no drop on the transmit side.
//  - Polarity toggles every cycle in normal operation. Behaviour with a stuck polarity is well-defined: only one VC drains.
//  - Reset mid-operation: buffered flits are lost; send falls to 0 immediately (async), without waiting for a clock edge.
// CONFIGURATION
//  - ROUTER_OC_STATS_EN defined:
//    - sent_cnt_vc1 / sent_cnt_vc2 increment on each pop of their VC.
//    - drop_cnt increments on each refused write.
//    - All three are 16-bit, saturate at 16'hFFFF, reset to 0, and are registered.
//  - ROUTER_OC_STATS_EN undefined:
//    - The three ports and their counters do not exist.
//    - All other behaviour is identical.
// TESTING
//  1. Reset with wr_valid=1, then release -> send=0, data_out=0, wr_ready_vc1=wr_ready_vc2=1.
//     - No flit is captured while reset_n=0.
//  2. Write 64'hA to VC1 at edge N, polarity=0 at edge N+1, ds_ready=1
//     -> send=1, data_out=64'hA after edge N+1. Following cycle: send=0.
//  3. Fill VC2 with 64'h1, 64'h2; third write 64'h3 -> wr_ready_vc2=0, flit dropped (drop_cnt=1 with stats).
//     - Drain over two polarity=1 cycles -> outputs 64'h1 then 64'h2.
//  4. VC1 and VC2 both hold one flit; ds_ready=0 for 4 cycles -> send stays 0, nothing lost.
//     - Then ds_ready=1 with alternating polarity -> VC1 flit on the polarity=0 edge, VC2 flit on the polarity=1 edge.
//  5. Write 64'h0 to VC1, then transmit -> send=1, data_out=0 (zero payload is valid).
//  6. Assert reset_n=0 between edges while send=1 -> send drops to 0 immediately; buffered flits gone after release.

Source files
------------

// File: rtl/router_oc_if.sv
// Crossbar-write and link-transmit signals of one router output channel.
interface router_oc_if #(
   parameter int unsigned DATA_W = 64
);
   logic              polarity;
   logic              wr_valid;
   logic              wr_vc;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready_vc1;
   logic              wr_ready_vc2;
   logic              ds_ready;
   logic              send;
   logic [DATA_W-1:0] data_out;

   // master: crossbar + downstream partner; slave: the output channel itself
   modport master (
      output polarity, wr_valid, wr_vc, wr_data, ds_ready,
      input  wr_ready_vc1, wr_ready_vc2, send, data_out
   );
   modport slave (
      input  polarity, wr_valid, wr_vc, wr_data, ds_ready,
      output wr_ready_vc1, wr_ready_vc2, send, data_out
   );
endinterface

// File: rtl/router_output_channel.sv
// Router output channel: two VC FIFOs drained by polarity onto a registered link.
// Optional ROUTER_OC_STATS_EN adds saturating sent/drop counters.
module router_output_channel #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned VC_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   router_oc_if.slave  oc
`ifdef ROUTER_OC_STATS_EN
   ,
   output logic [15:0] sent_cnt_vc1,
   output logic [15:0] sent_cnt_vc2,
   output logic [15:0] drop_cnt
`endif
);
   localparam int unsigned NUM_VC = 2;
   localparam int unsigned PTR_W  = $clog2(VC_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;

   logic [DATA_W-1:0] mem    [NUM_VC][VC_DEPTH];
   logic [PTR_W-1:0]  rd_ptr [NUM_VC];
   logic [PTR_W-1:0]  wr_ptr [NUM_VC];
   logic [CNT_W-1:0]  cnt    [NUM_VC];

   logic [NUM_VC-1:0] full_c;
   logic [NUM_VC-1:0] push_c;
   logic [NUM_VC-1:0] pop_c;
   logic              pop_any_c;
   logic [DATA_W-1:0] head_c;

   // Full is judged on occupancy alone, so a full VC refuses even while popping
   always_comb begin
      full_c = '0;
      push_c = '0;
      pop_c  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         full_c[v] = (cnt[v] == CNT_W'(VC_DEPTH));
         push_c[v] = oc.wr_valid && (oc.wr_vc == 1'(v)) && !full_c[v];
         pop_c[v]  = oc.ds_ready && (oc.polarity == 1'(v)) && (cnt[v] != '0);
      end
   end

   assign pop_any_c       = |pop_c;
   assign head_c          = mem[oc.polarity][rd_ptr[oc.polarity]];
   assign oc.wr_ready_vc1 = !full_c[0];
   assign oc.wr_ready_vc2 = !full_c[1];

   // Flit storage
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (push_c[v]) mem[v][wr_ptr[v]] <= oc.wr_data;
      end
   end

   // Pointers wrap naturally since VC_DEPTH is a power of two
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            rd_ptr[v] <= '0;
            wr_ptr[v] <= '0;
            cnt[v]    <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (push_c[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
            if (pop_c[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
            if (push_c[v] && !pop_c[v])      cnt[v] <= cnt[v] + CNT_W'(1);
            else if (!push_c[v] && pop_c[v]) cnt[v] <= cnt[v] - CNT_W'(1);
         end
      end
   end

   // Link stage; data_out is forced to zero whenever send is low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         oc.send     <= 1'b0;
         oc.data_out <= '0;
      end else begin
         oc.send     <= pop_any_c;
         oc.data_out <= pop_any_c ? head_c : '0;
      end
   end

`ifdef ROUTER_OC_STATS_EN
   logic drop_c;
   assign drop_c = oc.wr_valid && full_c[oc.wr_vc];

   // Saturating statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sent_cnt_vc1 <= '0;
         sent_cnt_vc2 <= '0;
         drop_cnt     <= '0;
      end else begin
         if (pop_c[0] && (sent_cnt_vc1 != 16'hFFFF)) sent_cnt_vc1 <= sent_cnt_vc1 + 16'(1);
         if (pop_c[1] && (sent_cnt_vc2 != 16'hFFFF)) sent_cnt_vc2 <= sent_cnt_vc2 + 16'(1);
         if (drop_c && (drop_cnt != 16'hFFFF))       drop_cnt     <= drop_cnt + 16'(1);
      end
   end
`endif

endmodule

// File: tb/tb_router_output_channel.sv
// Self-checking bench for router_output_channel: directed scenarios plus random traffic vs a queue model.
module tb_router_output_channel;
   localparam int unsigned DW    = 64;
   localparam int          DEPTH = 2;

   logic clk;
   logic reset_n;
   router_oc_if #(.DATA_W(DW)) oc ();

`ifdef ROUTER_OC_STATS_EN
   logic [15:0] sent_cnt_vc1, sent_cnt_vc2, drop_cnt;
`endif

   router_output_channel #(.DATA_W(DW), .VC_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .oc      (oc)
`ifdef ROUTER_OC_STATS_EN
      ,
      .sent_cnt_vc1 (sent_cnt_vc1),
      .sent_cnt_vc2 (sent_cnt_vc2),
      .drop_cnt     (drop_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: one FIFO queue per VC plus saturating statistics
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];
   logic [15:0]   m_sent1 = 0, m_sent2 = 0, m_drop = 0;

   logic          es, er1, er2, ar1, ar2;
   logic [DW-1:0] ed;

   function automatic logic [15:0] sat_inc(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   // Applies one cycle of inputs, advances the model, and returns predictions plus pre-edge wr_ready samples.
   task automatic run_cycle(input logic pol, input logic wv, input logic wvc, input logic [DW-1:0] wd,
                            input logic dsr, output logic exp_send, output logic [DW-1:0] exp_data,
                            output logic exp_r1, output logic exp_r2, output logic act_r1, output logic act_r2);
      int n1, n2;
      oc.polarity = pol;
      oc.wr_valid = wv;
      oc.wr_vc    = wvc;
      oc.wr_data  = wd;
      oc.ds_ready = dsr;
      n1 = q1.size();
      n2 = q2.size();
      exp_r1   = (n1 < DEPTH);
      exp_r2   = (n2 < DEPTH);
      exp_send = 1'b0;
      exp_data = '0;
      if (dsr && !pol && n1 > 0) begin
         exp_send = 1'b1;
         exp_data = q1.pop_front();
         m_sent1  = sat_inc(m_sent1);
      end else if (dsr && pol && n2 > 0) begin
         exp_send = 1'b1;
         exp_data = q2.pop_front();
         m_sent2  = sat_inc(m_sent2);
      end
      if (wv) begin
         if (!wvc) begin
            if (n1 < DEPTH) q1.push_back(wd); else m_drop = sat_inc(m_drop);
         end else begin
            if (n2 < DEPTH) q2.push_back(wd); else m_drop = sat_inc(m_drop);
         end
      end
      #2;
      act_r1 = oc.wr_ready_vc1;
      act_r2 = oc.wr_ready_vc2;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      oc.polarity = 1'b0;
      oc.wr_valid = 1'b1;
      oc.wr_vc    = 1'b0;
      oc.wr_data  = 64'hDEAD_BEEF;
      oc.ds_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (oc.send !== 1'b0 || oc.data_out !== '0 || oc.wr_ready_vc1 !== 1'b1 || oc.wr_ready_vc2 !== 1'b1)
         $display("FAIL reset_state: send=%b data=%h rdy1=%b rdy2=%b, expected 0 0 1 1",
                  oc.send, oc.data_out, oc.wr_ready_vc1, oc.wr_ready_vc2);
      else n_pass++;
`ifdef ROUTER_OC_STATS_EN
      n_total++;
      if (sent_cnt_vc1 !== 16'd0 || sent_cnt_vc2 !== 16'd0 || drop_cnt !== 16'd0)
         $display("FAIL reset_stats: sent1=%0d sent2=%0d drop=%0d, expected all 0",
                  sent_cnt_vc1, sent_cnt_vc2, drop_cnt);
      else n_pass++;
`endif
      oc.wr_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         run_cycle(1'(i), 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
         n_total++;
         if (oc.send !== 1'b0 || oc.data_out !== '0 || ar1 !== 1'b1 || ar2 !== 1'b1)
            $display("FAIL reset_no_capture: send=%b data=%h rdy1=%b rdy2=%b, expected 0 0 1 1",
                     oc.send, oc.data_out, ar1, ar2);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      run_cycle(1'b1, 1'b1, 1'b0, 64'hA, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b0) $display("FAIL single_write_edge: send=%b, expected 0", oc.send);
      else n_pass++;
      run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b1 || oc.data_out !== 64'hA)
         $display("FAIL single_tx: send=%b data=%h, expected 1 000000000000000a", oc.send, oc.data_out);
      else n_pass++;
      run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b0 || oc.data_out !== '0)
         $display("FAIL single_after: send=%b data=%h, expected 0 0", oc.send, oc.data_out);
      else n_pass++;
   endtask

   task automatic test_full_drop();
      logic [DW-1:0] wv [3];
      logic          rdy_exp [3];
      logic [DW-1:0] dv [3];
      logic          sv [3];
      wv = '{64'h1, 64'h2, 64'h3};
      rdy_exp = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b0, 1'b1, 1'b1, wv[i], 1'b1, es, ed, er1, er2, ar1, ar2);
         n_total++;
         if (ar2 !== rdy_exp[i] || oc.send !== 1'b0)
            $display("FAIL fill_vc2_%0d: rdy2=%b send=%b, expected %b 0", i, ar2, oc.send, rdy_exp[i]);
         else n_pass++;
      end
`ifdef ROUTER_OC_STATS_EN
      n_total++;
      if (drop_cnt !== 16'd1) $display("FAIL drop_cnt: got %0d, expected 1", drop_cnt);
      else n_pass++;
`endif
      dv = '{64'h1, 64'h2, 64'h0};
      sv = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
         n_total++;
         if (oc.send !== sv[i] || oc.data_out !== dv[i])
            $display("FAIL drain_vc2_%0d: send=%b data=%h, expected %b %h", i, oc.send, oc.data_out, sv[i], dv[i]);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      run_cycle(1'b1, 1'b1, 1'b0, 64'hC1, 1'b0, es, ed, er1, er2, ar1, ar2);
      run_cycle(1'b0, 1'b1, 1'b1, 64'hC2, 1'b0, es, ed, er1, er2, ar1, ar2);
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'(i), 1'b0, 1'b0, '0, 1'b0, es, ed, er1, er2, ar1, ar2);
         n_total++;
         if (oc.send !== 1'b0 || oc.data_out !== '0)
            $display("FAIL hold_%0d: send=%b data=%h, expected 0 0", i, oc.send, oc.data_out);
         else n_pass++;
      end
      run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b1 || oc.data_out !== 64'hC1)
         $display("FAIL hold_release_vc1: send=%b data=%h, expected 1 c1", oc.send, oc.data_out);
      else n_pass++;
      run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b1 || oc.data_out !== 64'hC2)
         $display("FAIL hold_release_vc2: send=%b data=%h, expected 1 c2", oc.send, oc.data_out);
      else n_pass++;
   endtask

   task automatic test_zero_payload();
      run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, es, ed, er1, er2, ar1, ar2);
      run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b1 || oc.data_out !== '0)
         $display("FAIL zero_payload: send=%b data=%h, expected 1 0", oc.send, oc.data_out);
      else n_pass++;
   endtask

   task automatic test_random();
      logic pol;
      int   errs;
      pol  = 1'b0;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         // Mostly toggling polarity, with occasional stuck stretches
         if ($urandom_range(0, 9) != 0) pol = ~pol;
         run_cycle(pol, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 3) != 0),
                   es, ed, er1, er2, ar1, ar2);
         n_total++;
         if (oc.send !== es || oc.data_out !== ed || ar1 !== er1 || ar2 !== er2) begin
            if (errs < 10)
               $display("FAIL random_cycle_%0d: send=%b data=%h rdy=%b%b, expected %b %h %b%b",
                        i, oc.send, oc.data_out, ar1, ar2, es, ed, er1, er2);
            errs++;
         end else n_pass++;
      end
`ifdef ROUTER_OC_STATS_EN
      n_total++;
      if (sent_cnt_vc1 !== m_sent1 || sent_cnt_vc2 !== m_sent2 || drop_cnt !== m_drop)
         $display("FAIL random_stats: sent1=%0d sent2=%0d drop=%0d, expected %0d %0d %0d",
                  sent_cnt_vc1, sent_cnt_vc2, drop_cnt, m_sent1, m_sent2, m_drop);
      else n_pass++;
`endif
   endtask

   task automatic test_async_reset();
      // Flush any leftovers from earlier traffic so the directed sequence starts clean
      for (int i = 0; i < 6; i++) run_cycle(1'(i), 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      run_cycle(1'b1, 1'b1, 1'b0, 64'h55, 1'b0, es, ed, er1, er2, ar1, ar2);
      run_cycle(1'b1, 1'b1, 1'b0, 64'h66, 1'b0, es, ed, er1, er2, ar1, ar2);
      run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
      n_total++;
      if (oc.send !== 1'b1 || oc.data_out !== 64'h55)
         $display("FAIL areset_pre: send=%b data=%h, expected 1 55", oc.send, oc.data_out);
      else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (oc.send !== 1'b0 || oc.data_out !== '0)
         $display("FAIL areset_immediate: send=%b data=%h, expected 0 0", oc.send, oc.data_out);
      else n_pass++;
      q1.delete();
      q2.delete();
      m_sent1 = 0;
      m_sent2 = 0;
      m_drop  = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'(i), 1'b0, 1'b0, '0, 1'b1, es, ed, er1, er2, ar1, ar2);
         n_total++;
         if (oc.send !== 1'b0 || oc.data_out !== '0 || ar1 !== 1'b1)
            $display("FAIL areset_flushed_%0d: send=%b data=%h rdy1=%b, expected 0 0 1",
                     i, oc.send, oc.data_out, ar1);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_drop();
      test_hold();
      test_zero_payload();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Hard stop in case anything above stalls
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", n_pass, n_total);
      $fatal(1);
   end
endmodule
